// File: rtl/module_frame_rx_pkg.sv
// Shared UART frame-format constants, parameter defaults and bit-receiver state type
// for the module-side frame receiver.
package module_frame_rx_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam bit UART_PARITY_EVEN = 1'b1;
  localparam int UART_STOP_BITS   = 1;

  localparam int DEF_CLKS_PER_BIT  = 208;
  localparam int DEF_NUM_OF_PHASES = 3;
  localparam int DEF_TIMEOUT_CLKS  = 4160;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Parity bit the sender must transmit for a given data byte.
  function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] d);
    return UART_PARITY_EVEN ? ^d : ~^d;
  endfunction

endpackage

// File: rtl/module_frame_rx_bit_rx.sv
// UART bit receiver: rx synchronizer, start/data/parity/stop FSM and byte check.
// Emits a one-cycle byte_ok or byte_bad at the stop-bit centre.
module uart_bit_rx
  import module_frame_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_byte,
  output logic                      byte_ok,
  output logic                      byte_bad,
  output logic                      parity_fail,
  output logic                      stop_fail,
  output rx_state_t                 state_dbg
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(UART_DATA_BITS - 1);

  logic rx_meta, rx_sync, rx_prev;
  logic rx_fall;

  rx_state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic par_q;

  logic bit_tick, half_tick;
  logic cnt_clr, done, pf_c, sf_c;

  assign rx_fall   = rx_prev & ~rx_sync;
  assign bit_tick  = (cnt == BIT_LAST);
  assign half_tick = (cnt == HALF_LAST);
  assign state_dbg = state;

  // Line idles high, so the synchronizer presets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = (state == RX_IDLE);
    done       = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rx_fall) state_next = RX_START;
      end
      RX_START: begin
        if (half_tick) begin
          cnt_clr    = 1'b1;
          state_next = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_tick) begin
          cnt_clr = 1'b1;
          if (bit_idx == IDX_LAST) state_next = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (bit_tick) begin
          cnt_clr    = 1'b1;
          state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_tick) begin
          cnt_clr    = 1'b1;
          done       = 1'b1;
          state_next = RX_IDLE;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign pf_c = done && (par_q != parity_bit(shreg));
  assign sf_c = done && !rx_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_q       <= 1'b0;
      rx_byte     <= '0;
      byte_ok     <= 1'b0;
      byte_bad    <= 1'b0;
      parity_fail <= 1'b0;
      stop_fail   <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (state == RX_START) bit_idx <= '0;
      if (state == RX_DATA && bit_tick) begin
        shreg   <= {rx_sync, shreg[UART_DATA_BITS-1:1]};
        bit_idx <= bit_idx + BW'(1);
      end
      if (state == RX_PARITY && bit_tick) par_q <= rx_sync;
      if (done) rx_byte <= shreg;
      byte_ok     <= done & ~pf_c & ~sf_c;
      byte_bad    <= pf_c | sf_c;
      parity_fail <= pf_c;
      stop_fail   <= sf_c;
    end
  end

endmodule

// File: rtl/module_frame_rx.sv
// Power-module frame receiver: assembles NUM_OF_PHASES bytes into a pending frame
// and applies it to phase_val on the synchronized rising edge of shoot.
module module_frame_rx
  import module_frame_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int NUM_OF_PHASES = DEF_NUM_OF_PHASES,
  parameter int TIMEOUT_CLKS  = DEF_TIMEOUT_CLKS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx,
  input  logic                       shoot,
  output logic [8*NUM_OF_PHASES-1:0] phase_val,
  output logic                       out_valid,
  output logic                       frame_pending,
  output logic                       err_parity,
  output logic                       err_frame,
  output rx_state_t                  rx_state_dbg
);

  localparam int FW = 8 * NUM_OF_PHASES;
  localparam int IW = (NUM_OF_PHASES > 1) ? $clog2(NUM_OF_PHASES) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_OF_PHASES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [TW-1:0] TO_SAT   = TW'(TIMEOUT_CLKS);

  logic [7:0] rx_byte;
  logic byte_ok, byte_bad, parity_fail, stop_fail;

  uart_bit_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_rx (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_byte     (rx_byte),
    .byte_ok     (byte_ok),
    .byte_bad    (byte_bad),
    .parity_fail (parity_fail),
    .stop_fail   (stop_fail),
    .state_dbg   (rx_state_dbg)
  );

  logic shoot_meta, shoot_sync, shoot_prev, shoot_edge;
  logic [IW-1:0] idx;
  logic [FW-1:0] stage, stage_next, pending;
  logic [TW-1:0] idle_cnt;
  logic last_byte, timeout;

  // Edge is registered so the apply lands 4 clocks after the shoot pin rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shoot_meta <= 1'b0;
      shoot_sync <= 1'b0;
      shoot_prev <= 1'b0;
      shoot_edge <= 1'b0;
    end else begin
      shoot_meta <= shoot;
      shoot_sync <= shoot_meta;
      shoot_prev <= shoot_sync;
      shoot_edge <= shoot_sync & ~shoot_prev;
    end
  end

  always_comb begin
    stage_next = stage;
    stage_next[8*int'(idx) +: 8] = rx_byte;
  end

  assign last_byte = byte_ok && (idx == IDX_LAST);
  assign timeout   = (idx != '0) && (idle_cnt == TO_LAST) && !byte_ok && !byte_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      stage    <= '0;
      pending  <= '0;
      idle_cnt <= '0;
    end else begin
      if (byte_ok)                 idle_cnt <= '0;
      else if (idle_cnt != TO_SAT) idle_cnt <= idle_cnt + TW'(1);

      if (byte_bad) begin
        idx <= '0;
      end else if (byte_ok) begin
        stage <= stage_next;
        if (last_byte) begin
          pending <= stage_next;
          idx     <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end else if (timeout) begin
        idx <= '0;
      end
    end
  end

  // A completing frame wins over a same-cycle shoot clearing frame_pending;
  // the shoot still applies the previously pending contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_val     <= '0;
      out_valid     <= 1'b0;
      frame_pending <= 1'b0;
      err_parity    <= 1'b0;
      err_frame     <= 1'b0;
    end else begin
      if (shoot_edge && frame_pending) begin
        phase_val <= pending;
        out_valid <= 1'b1;
      end
      if (last_byte)       frame_pending <= 1'b1;
      else if (shoot_edge) frame_pending <= 1'b0;
      if (byte_bad && parity_fail)           err_parity <= 1'b1;
      if ((byte_bad && stop_fail) || timeout) err_frame <= 1'b1;
    end
  end

endmodule

// File: tb/tb_module_frame_rx.sv
// Directed bench for module_frame_rx: frames, parity/timeout errors, shoot
// behaviour, shoot/completion collision and mid-byte reset.
module tb_module_frame_rx;
  import module_frame_rx_pkg::*;

  localparam int CPB  = 16;
  localparam int N    = 3;
  localparam int TO   = 320;
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  logic reset, rx, shoot;
  logic [8*N-1:0] phase_val;
  logic out_valid, frame_pending, err_parity, err_frame;
  rx_state_t rx_state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  module_frame_rx #(.CLKS_PER_BIT(CPB), .NUM_OF_PHASES(N), .TIMEOUT_CLKS(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .shoot         (shoot),
    .phase_val     (phase_val),
    .out_valid     (out_valid),
    .frame_pending (frame_pending),
    .err_parity    (err_parity),
    .err_frame     (err_frame),
    .rx_state_dbg  (rx_state_dbg)
  );

  // Inputs change on the falling edge, well away from the sampling edge.
  task automatic send_byte(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic par;
    par = (^d) ^ bad_par;
    @(negedge clk); rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = par;
    repeat (CPB) @(negedge clk);
    rx = ~bad_stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [23:0] f);
    send_byte(f[7:0], 1'b0, 1'b0);
    send_byte(f[15:8], 1'b0, 1'b0);
    send_byte(f[23:16], 1'b0, 1'b0);
  endtask

  task automatic pulse_shoot();
    @(negedge clk); shoot = 1'b1;
    repeat (3) @(negedge clk);
    shoot = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; shoot = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (phase_val !== 24'h0) begin errors++; $display("FAIL reset_phase_val: got %h expected %h", phase_val, 24'h0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL reset_frame_pending: got %b expected 0", frame_pending); end
    checks++; if (err_parity !== 1'b0) begin errors++; $display("FAIL reset_err_parity: got %b expected 0", err_parity); end
    checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL reset_err_frame: got %b expected 0", err_frame); end
    checks++; if (rx_state_dbg !== RX_IDLE) begin errors++; $display("FAIL reset_rx_state: got %0d expected %0d", rx_state_dbg, RX_IDLE); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    send_frame(24'h563412);
    checks++; if (frame_pending !== 1'b1) begin errors++; $display("FAIL basic_pending: got %b expected 1", frame_pending); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_before_shoot: got %b expected 0", out_valid); end
    checks++; if (phase_val !== 24'h0) begin errors++; $display("FAIL basic_phase_before_shoot: got %h expected %h", phase_val, 24'h0); end
    pulse_shoot();
    checks++; if (phase_val !== 24'h563412) begin errors++; $display("FAIL basic_phase_val: got %h expected %h", phase_val, 24'h563412); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
    checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL basic_pending_cleared: got %b expected 0", frame_pending); end
    checks++; if ({err_parity, err_frame} !== 2'b00) begin errors++; $display("FAIL basic_no_errors: got %b expected 00", {err_parity, err_frame}); end
  endtask

  task automatic test_parity_error();
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    checks++; if (err_parity !== 1'b1) begin errors++; $display("FAIL parity_flag: got %b expected 1", err_parity); end
    checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL parity_no_frame_err: got %b expected 0", err_frame); end
    send_frame(24'h9A7856);
    pulse_shoot();
    checks++; if (phase_val !== 24'h9A7856) begin errors++; $display("FAIL parity_phase_val: got %h expected %h", phase_val, 24'h9A7856); end
    checks++; if (err_parity !== 1'b1) begin errors++; $display("FAIL parity_sticky: got %b expected 1", err_parity); end
  endtask

  task automatic test_timeout();
    send_byte(8'hAA, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", err_frame); end
    repeat (300) @(negedge clk);
    checks++; if (err_frame !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", err_frame); end
    checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL timeout_no_pending: got %b expected 0", frame_pending); end
    send_frame(24'h030201);
    pulse_shoot();
    checks++; if (phase_val !== 24'h030201) begin errors++; $display("FAIL timeout_phase_val: got %h expected %h", phase_val, 24'h030201); end
  endtask

  task automatic test_shoot_without_frame();
    send_frame(24'h111111);
    pulse_shoot();
    checks++; if (phase_val !== 24'h111111) begin errors++; $display("FAIL noframe_applied: got %h expected %h", phase_val, 24'h111111); end
    pulse_shoot();
    pulse_shoot();
    checks++; if (phase_val !== 24'h111111) begin errors++; $display("FAIL noframe_phase_hold: got %h expected %h", phase_val, 24'h111111); end
    checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL noframe_pending: got %b expected 0", frame_pending); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL noframe_valid: got %b expected 1", out_valid); end
  endtask

  // Shoot pin timed so its registered edge coincides with the last byte_ok of frame B.
  task automatic test_shoot_collision();
    send_frame(24'h0A0A0A);
    send_byte(8'h0D, 1'b0, 1'b0);
    send_byte(8'h0C, 1'b0, 1'b0);
    fork
      send_byte(8'h0B, 1'b0, 1'b0);
      begin
        repeat (10 * CPB + HALF + 1) @(negedge clk);
        shoot = 1'b1;
        repeat (3) @(negedge clk);
        shoot = 1'b0;
      end
    join
    checks++; if (phase_val !== 24'h0A0A0A) begin errors++; $display("FAIL collision_old_applied: got %h expected %h", phase_val, 24'h0A0A0A); end
    checks++; if (frame_pending !== 1'b1) begin errors++; $display("FAIL collision_new_pending: got %b expected 1", frame_pending); end
    pulse_shoot();
    checks++; if (phase_val !== 24'h0B0C0D) begin errors++; $display("FAIL collision_next_shoot: got %h expected %h", phase_val, 24'h0B0C0D); end
    checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL collision_pending_cleared: got %b expected 0", frame_pending); end
  endtask

  task automatic test_reset_mid_byte();
    @(negedge clk); rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB + HALF) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (phase_val !== 24'h0) begin errors++; $display("FAIL midreset_phase_val: got %h expected %h", phase_val, 24'h0); end
    checks++; if ({out_valid, frame_pending} !== 2'b00) begin errors++; $display("FAIL midreset_valid_pending: got %b expected 00", {out_valid, frame_pending}); end
    checks++; if ({err_parity, err_frame} !== 2'b00) begin errors++; $display("FAIL midreset_errors: got %b expected 00", {err_parity, err_frame}); end
    checks++; if (rx_state_dbg !== RX_IDLE) begin errors++; $display("FAIL midreset_state: got %0d expected %0d", rx_state_dbg, RX_IDLE); end
    rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    send_frame(24'h654321);
    pulse_shoot();
    checks++; if (phase_val !== 24'h654321) begin errors++; $display("FAIL midreset_phase_after: got %h expected %h", phase_val, 24'h654321); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midreset_valid_after: got %b expected 1", out_valid); end
    checks++; if ({err_parity, err_frame} !== 2'b00) begin errors++; $display("FAIL midreset_errors_after: got %b expected 00", {err_parity, err_frame}); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_error();
    test_timeout();
    test_shoot_without_frame();
    test_shoot_collision();
    test_reset_mid_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/module_frame_rx.md
# module_frame_rx

Module-side receiver for the inverter's main-FPGA → power-module UART link. It deserializes bytes sent by the main FPGA (one byte per phase, `NUM_OF_PHASES` bytes per frame) and checks parity and framing. Each complete frame is staged in a pending buffer and transferred to the output registers on the rising edge of the shared `shoot` pulse, so all modules update their switch commands simultaneously. It sits on each power-module FPGA, directly behind the rx pin and shoot pin.

## Interface
- `CLKS_PER_BIT`, 208, clk cycles per UART bit (24 MHz / 115200).
- `NUM_OF_PHASES`, 3, data bytes per frame.
- `TIMEOUT_CLKS`, 4160, idle clk cycles between bytes (20 bit times) after which a partial frame is discarded.
- `clk` input 1, system clock (24 MHz, HFOSC/2).
- `reset` input 1, asynchronous, active-high.
- `rx` input 1, UART line from main FPGA, idle high, asynchronous to `clk`.
- `shoot` input 1, global apply strobe, asynchronous to `clk`.
- `phase_val` output 8*NUM_OF_PHASES, applied phase bytes, phase 0 in bits [7:0].
- `out_valid` output 1, high once at least one frame has been applied.
- `frame_pending` output 1, a complete frame is staged and awaiting `shoot`.
- `err_parity` output 1, sticky, a byte failed even parity since reset.
- `err_frame` output 1, sticky, a byte had stop bit low, or a partial frame timed out.

## Operation
- Reset values: `phase_val`=0, `out_valid`=0, `frame_pending`=0, `err_parity`=0, `err_frame`=0. Synchronizers are preset to 1 for `rx` and 0 for `shoot`. The byte index is 0 and the bit-receiver FSM is IDLE.
- Line format: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
- Bit-receiver FSM: IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: wait for a falling edge on synchronized rx.
  - START: after CLKS_PER_BIT/2 cycles, resample. If rx is high, treat it as a glitch and return to IDLE.
  - DATA: sample each bit at CLKS_PER_BIT intervals from the start-bit centre.
  - PARITY: sample the parity bit.
  - STOP: sample the stop bit, then emit a one-cycle `byte_ok` or `byte_bad` and return to IDLE.
- `byte_bad` conditions: parity mismatch sets `err_parity`; stop bit = 0 sets `err_frame`.
- `byte_bad` handling: the byte is discarded, the byte index is cleared to 0, and the staging buffer is unchanged.
- `byte_ok` handling: the byte is written to `stage[index]` and the index increments.
- Frame completion: when index reaches NUM_OF_PHASES, the frame is complete. Copy stage to the pending buffer, set `frame_pending`, and clear the index to 0.
- Overwrite: a new complete frame overwrites an un-applied pending frame. This is not an error.
- Timeout: an inter-byte idle counter starts at each `byte_ok`. If it reaches TIMEOUT_CLKS while index ≠ 0, clear the index and set `err_frame`.
- Shoot rising edge (synchronized):
  - If `frame_pending`=1: copy pending → `phase_val`, set `out_valid`, clear `frame_pending`.
  - If `frame_pending`=0: `phase_val` holds its value. This is not an error.
- Simultaneous shoot edge and frame completion in the same cycle: the shoot applies the old pending contents, if any. The new frame becomes pending and `frame_pending` stays 1.
- Asserting reset mid-byte or mid-frame abandons all progress immediately. After release, wait for a fresh falling edge.

## Timing
- `rx` and `shoot` each pass through a 2-FF synchronizer. Edge detect uses a third register.
- `byte_ok`/`byte_bad` fire at the stop-bit centre: 10.5·CLKS_PER_BIT + 3 cycles after the start edge on the pin (±1).
- `frame_pending` rises 1 cycle after the last `byte_ok`.
- `phase_val` and `out_valid` update 4 cycles after the `shoot` pin rises (2 sync + 1 edge + 1 register).
- `shoot` is ≥2 clk wide. A new rising edge must be ≥3 clk after the previous one.
- Error flags set 1 cycle after the causing event.

## Structure
- Shared package/header `UART.vh` holds the frame-format constants: data bits = 8, even parity, stop bits = 1. `CLKS_PER_BIT` and `NUM_OF_PHASES` defaults come from `macros.vh`.
- One sub-module, `uart_bit_rx`: synchronizer, bit FSM and parity/stop check, outputting `byte`, `byte_ok` and `byte_bad`.
- Frame assembly, timeout, pending buffer and shoot logic live in the top of the block.

## Test plan
- Send frame 0x12, 0x34, 0x56, then pulse `shoot` → `phase_val`=0x563412 and `out_valid`=1. Before shoot, `frame_pending`=1.
- Send 0x12, 0x34 with a bad parity bit, then 0x56, 0x78, 0x9A, then shoot → `err_parity`=1 and `phase_val`=0x9A7856.
- Send 0xAA only, idle > TIMEOUT_CLKS, then send 0x01, 0x02, 0x03 and shoot → `err_frame`=1 and `phase_val`=0x030201.
- Apply 0x111111, then pulse shoot twice with no new frame → `phase_val` stays 0x111111 and `frame_pending`=0.
- Align the shoot edge-detect with the completion of frame B (pending A=0x0A0A0A) → `phase_val`=0x0A0A0A, then B pending. The next shoot applies B.
- Assert reset mid-data-bit of a byte, release, send a full frame and shoot → all outputs 0 during reset, then correct frame applied and no error flags.
